// File: rtl/input_block_buffer_pkg.sv
// Shared definitions for the raster <-> 2x8 block reorder paths.
// Holds the pixel geometry constants and the index/pack helpers for the
// 4-pixel beat layout and the 2x8x3 block layout, which the decoder output
// path uses as well.
package input_block_buffer_pkg;

  localparam int unsigned PIX_W    = 14;
  localparam int unsigned NUM_COMP = 3;
  localparam int unsigned BEAT_PIX = 4;
  localparam int unsigned BLK_W    = 8;
  localparam int unsigned BLK_H    = 2;

  localparam int unsigned BEAT_W  = BEAT_PIX * NUM_COMP * PIX_W;
  localparam int unsigned ENTRY_W = BLK_W * NUM_COMP * PIX_W;
  localparam int unsigned BLOCK_W = BLK_H * BLK_W * NUM_COMP * PIX_W;

  // Bit offset of pixel p, component c in a beat. Also valid for an 8-pixel
  // line entry, which is two beats concatenated with the left beat in the LSBs.
  function automatic int unsigned beat_idx(input int unsigned p, input int unsigned c);
    return (p * NUM_COMP + c) * PIX_W;
  endfunction

  // Bit offset of component c, row r, column k in a block.
  function automatic int unsigned blk_idx(input int unsigned c, input int unsigned r,
                                          input int unsigned k);
    return (c * BLK_H * BLK_W + r * BLK_W + k) * PIX_W;
  endfunction

  // Beat whose four pixels are all copies of the rightmost pixel.
  function automatic logic [BEAT_W-1:0] pad_beat(input logic [BEAT_W-1:0] beat);
    logic [BEAT_W-1:0] res;
    res = '0;
    for (int unsigned p = 0; p < BEAT_PIX; p++) begin
      for (int unsigned c = 0; c < NUM_COMP; c++) begin
        res[beat_idx(p, c) +: PIX_W] = beat[beat_idx(BEAT_PIX - 1, c) +: PIX_W];
      end
    end
    return res;
  endfunction

  // Two 8-pixel line entries (even row, odd row) to block layout.
  function automatic logic [BLOCK_W-1:0] pack_block(input logic [ENTRY_W-1:0] row0,
                                                    input logic [ENTRY_W-1:0] row1);
    logic [BLOCK_W-1:0] res;
    res = '0;
    for (int unsigned c = 0; c < NUM_COMP; c++) begin
      for (int unsigned k = 0; k < BLK_W; k++) begin
        res[blk_idx(c, 0, k) +: PIX_W] = row0[beat_idx(k, c) +: PIX_W];
        res[blk_idx(c, 1, k) +: PIX_W] = row1[beat_idx(k, c) +: PIX_W];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dp_ram.sv
// Simple dual-port line RAM: one write port, one read port, 1-cycle read.
// Ports:
//   clk, rst_n         clock, async active-low reset (mem_valid only)
//   wr_en/wr_addr/wr_data  write port
//   rd_en/rd_addr      read request
//   rd_data            read data, valid the cycle after rd_en
//   mem_valid          high when rd_data carries a fresh read
module dp_ram #(
  parameter int unsigned NUMBER_OF_LINES = 320,
  parameter int unsigned DATA_WIDTH      = 336,
  parameter int unsigned ADDR_WIDTH      = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  mem_valid
);

  logic [DATA_WIDTH-1:0] mem_q [NUMBER_OF_LINES];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_valid <= 1'b0;
    else        mem_valid <= rd_en;
  end

endmodule

// File: rtl/input_block_buffer.sv
// Encoder-side pixel reorder buffer: raster beats of 4 pixels in, 2x8 blocks out.
// Even rows are parked in a slice-wide line RAM (8 pixels per entry); the odd
// row reads them back and pairs them with its own pixels to form blocks.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   sof            first beat of a slice
//   slice_width    pixels per row (multiple of 4, >= 8)
//   in_valid       beat qualifier
//   in_data_p      4 pixels x 3 components
//   out_blk_valid  one-cycle block qualifier
//   out_blk_p      2x8x3 block
//   out_sof        marks the first block of a slice
module input_block_buffer
  import input_block_buffer_pkg::*;
#(
  parameter int unsigned MAX_SLICE_WIDTH = 2560
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               sof,
  input  logic [$clog2(MAX_SLICE_WIDTH)-1:0] slice_width,
  input  logic                               in_valid,
  input  logic [BEAT_W-1:0]                  in_data_p,
  output logic                               out_blk_valid,
  output logic [BLOCK_W-1:0]                 out_blk_p,
  output logic                               out_sof
);

  localparam int unsigned SwW   = $clog2(MAX_SLICE_WIDTH);
  localparam int unsigned Lines = (MAX_SLICE_WIDTH + 7) / 8;
  localparam int unsigned AddrW = (Lines > 1) ? $clog2(Lines) : 1;
  localparam int unsigned CbW   = SwW - 2;

  logic [CbW-1:0]     col_beat_q;
  logic               odd_row_q;
  logic               active_q;
  logic               tail_pend_q;
  logic               sof_pend_q;
  logic [BEAT_W-1:0]  hold_q;
  logic [ENTRY_W-1:0] ram_hold_q;

  logic               beat, row_odd, last_beat, beat_odd;
  logic [CbW-1:0]     cb_cur, last_idx;
  logic [AddrW-1:0]   addr;
  logic               wr_en, rd_en, mem_valid;
  logic [ENTRY_W-1:0] wr_data, rd_data, ram_row, row1;
  logic               emit_norm, emit_tail, emit, tail_start;
  logic               unused_sw;

  assign unused_sw = ^slice_width[1:0];

  // Beats are ignored until a sof is seen after reset.
  assign beat      = in_valid & (sof | active_q);
  // sof restarts the slice before its own beat is processed.
  assign cb_cur    = sof ? '0 : col_beat_q;
  assign row_odd   = sof ? 1'b0 : odd_row_q;
  assign last_idx  = slice_width[SwW-1:2] - CbW'(1);
  assign last_beat = (cb_cur == last_idx);
  assign beat_odd  = cb_cur[0];
  assign addr      = AddrW'(cb_cur >> 1);

  // Even row: a pair of beats, or a lone padded tail beat, becomes one entry.
  assign wr_en   = beat & ~row_odd & (beat_odd | last_beat);
  assign wr_data = beat_odd ? {in_data_p, hold_q} : {pad_beat(in_data_p), in_data_p};

  // Odd row: the first beat of each pair fetches the matching even-row entry.
  assign rd_en      = beat & row_odd & ~beat_odd;
  assign tail_start = rd_en & last_beat;
  assign emit_norm  = beat & row_odd & beat_odd;
  // A lone tail already has its pixels in hold_q; it waits only for the RAM.
  assign emit_tail  = tail_pend_q & mem_valid;
  assign emit       = emit_norm | emit_tail;

  // Read data is transient; fall back to the captured copy after input gaps.
  assign ram_row = mem_valid ? rd_data : ram_hold_q;
  assign row1    = emit_norm ? {in_data_p, hold_q} : {pad_beat(hold_q), hold_q};

  dp_ram #(
    .NUMBER_OF_LINES(Lines),
    .DATA_WIDTH     (ENTRY_W),
    .ADDR_WIDTH     (AddrW)
  ) u_line_ram (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_addr  (addr),
    .rd_data  (rd_data),
    .mem_valid(mem_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_beat_q    <= '0;
      odd_row_q     <= 1'b0;
      active_q      <= 1'b0;
      tail_pend_q   <= 1'b0;
      sof_pend_q    <= 1'b0;
      hold_q        <= '0;
      ram_hold_q    <= '0;
      out_blk_valid <= 1'b0;
      out_blk_p     <= '0;
      out_sof       <= 1'b0;
    end else begin
      if (sof) active_q <= 1'b1;

      if (beat) begin
        if (last_beat) begin
          col_beat_q <= '0;
          odd_row_q  <= ~row_odd;
        end else begin
          col_beat_q <= cb_cur + CbW'(1);
          odd_row_q  <= row_odd;
        end
        if (!beat_odd) hold_q <= in_data_p;
      end

      if (mem_valid) ram_hold_q <= rd_data;

      // A pending tail belongs to a completed row, so a following sof keeps it.
      if (tail_start)     tail_pend_q <= 1'b1;
      else if (emit_tail) tail_pend_q <= 1'b0;

      if (sof)       sof_pend_q <= 1'b1;
      else if (emit) sof_pend_q <= 1'b0;

      out_blk_valid <= emit;
      if (emit) begin
        out_blk_p <= pack_block(ram_row, row1);
        out_sof   <= sof_pend_q;
      end else begin
        out_sof   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_block_buffer.sv
// Scoreboard bench for input_block_buffer: stimulus pushes expected blocks
// (data, out_sof, arrival cycle) built from a per-slice image; a forked
// monitor pops and compares every emitted block.
module tb_input_block_buffer;
  import input_block_buffer_pkg::*;

  localparam int unsigned MAXW = 2560;
  localparam int unsigned SW_W = $clog2(MAXW);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sof = 1'b0;
  logic [SW_W-1:0]    slice_width = '0;
  logic               in_valid = 1'b0;
  logic [BEAT_W-1:0]  in_data_p = '0;
  logic               out_blk_valid;
  logic [BLOCK_W-1:0] out_blk_p;
  logic               out_sof;

  input_block_buffer #(.MAX_SLICE_WIDTH(MAXW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sof          (sof),
    .slice_width  (slice_width),
    .in_valid     (in_valid),
    .in_data_p    (in_data_p),
    .out_blk_valid(out_blk_valid),
    .out_blk_p    (out_blk_p),
    .out_sof      (out_sof)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BLOCK_W-1:0] blk;
    logic               sof;
    int unsigned        cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_err = 0;
  logic [PIX_W-1:0] img [4][MAXW][NUM_COMP];

  task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                       input logic [BLOCK_W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_blk_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_block: valid at cycle %0d, expected no block", cyc);
        end else begin
          e = exp_q.pop_front();
          check("blk_data", out_blk_p, e.blk);
          check("blk_sof", BLOCK_W'(out_sof), BLOCK_W'(e.sof));
          check("blk_cycle", BLOCK_W'(cyc), BLOCK_W'(e.cyc));
        end
      end
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
      sof = 1'b0;
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic s, input int unsigned w, input logic [BEAT_W-1:0] d);
    @(posedge clk);
    #1;
    sof = s;
    slice_width = SW_W'(w);
    in_valid = 1'b1;
    in_data_p = d;
  endtask

  // Expected block: rows r1-1 and r1, columns 8*blk.., clamped at the right edge.
  task automatic push_block(input int unsigned r1, input int unsigned w, input int unsigned blk,
                            input int unsigned t, input bit s);
    exp_t e;
    int unsigned col;
    e.blk = '0;
    for (int unsigned c = 0; c < NUM_COMP; c++) begin
      for (int unsigned rr = 0; rr < 2; rr++) begin
        for (int unsigned k = 0; k < 8; k++) begin
          col = blk * 8 + k;
          if (col > w - 1) col = w - 1;
          e.blk[((c * 2 + rr) * 8 + k) * PIX_W +: PIX_W] = img[r1 - 1 + rr][col][c];
        end
      end
    end
    e.sof = s;
    e.cyc = t;
    exp_q.push_back(e);
  endtask

  // stop_beat >= 0 ends the slice just before that beat of its last row.
  task automatic run_slice(input int unsigned w, input int unsigned rows, input int stop_beat,
                           input bit gaps, input bit rnd);
    int unsigned       nb;
    bit                first;
    logic [BEAT_W-1:0] d;
    nb = w / 4;
    first = 1'b1;
    for (int unsigned r = 0; r < rows; r++) begin
      for (int unsigned col = 0; col < w; col++) begin
        for (int unsigned c = 0; c < NUM_COMP; c++) begin
          img[r][col][c] = rnd ? PIX_W'($urandom) : PIX_W'(r * 100 + col);
        end
      end
    end
    for (int unsigned r = 0; r < rows; r++) begin
      for (int unsigned b = 0; b < nb; b++) begin
        if (stop_beat >= 0 && r == rows - 1 && b == unsigned'(stop_beat)) return;
        if (gaps && !(r == 0 && b == 0)) idle($urandom_range(2, 0));
        d = '0;
        for (int unsigned p = 0; p < 4; p++) begin
          for (int unsigned c = 0; c < NUM_COMP; c++) begin
            d[(p * NUM_COMP + c) * PIX_W +: PIX_W] = img[r][4 * b + p][c];
          end
        end
        drive_beat(r == 0 && b == 0, w, d);
        if (r % 2 == 1) begin
          if (b % 2 == 1) begin
            push_block(r, w, b / 2, cyc + 1, first);
            first = 1'b0;
          end else if (b == nb - 1) begin
            push_block(r, w, b / 2, cyc + 2, first);
            first = 1'b0;
          end
        end
      end
    end
  endtask

  initial begin
    int unsigned guard;
    fork
      monitor();
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", BLOCK_W'(out_blk_valid), '0);
    check("rst_sof", BLOCK_W'(out_sof), '0);
    check("rst_blk", out_blk_p, '0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    run_slice(16, 2, -1, 1'b0, 1'b0);
    idle(4);
    run_slice(12, 2, -1, 1'b0, 1'b0);
    idle(4);
    run_slice(16, 4, -1, 1'b1, 1'b0);
    idle(4);
    run_slice(2560, 2, -1, 1'b0, 1'b0);
    idle(4);

    // Abort in the middle of an odd row; the new slice starts immediately.
    run_slice(32, 2, 3, 1'b0, 1'b0);
    run_slice(16, 2, -1, 1'b0, 1'b1);
    idle(4);

    // Reset mid-row, then beats without sof must be ignored.
    run_slice(16, 2, 3, 1'b0, 1'b1);
    idle(3);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", BLOCK_W'(out_blk_valid), '0);
    check("midrst_sof", BLOCK_W'(out_sof), '0);
    check("midrst_blk", out_blk_p, '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) drive_beat(1'b0, 16, {6{28'($urandom)}});
    idle(4);
    run_slice(16, 2, -1, 1'b0, 1'b1);
    idle(3);

    // Random widths, row counts, gaps and slice spacing.
    for (int i = 0; i < 10; i++) begin
      run_slice(4 * $urandom_range(16, 2), ($urandom_range(1, 0) == 1) ? 4 : 2, -1,
                1'(($urandom_range(1, 0))), 1'b1);
      idle($urandom_range(3, 0));
    end

    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    idle(4);
    check("queue_drained", BLOCK_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
